// File: rtl/usr_shift_sequencer.sv
// Command-driven sequencer for a 4-bit universal shift register (USR).
// Each accepted command parallel-loads the USR once, then applies N
// shift/rotate steps, then pulses done with the USR contents on result.
//
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   cmd_valid/ready  host command handshake (ready only in IDLE)
//   cmd_op           000 load, 001 SRL, 010 SLL, 011 ROR, 100 ROL, 101 SRA
//   cmd_count        shift steps after the load
//   cmd_data         value parallel-loaded into the USR
//   usr_sel          USR mode: 00 hold, 01 right, 10 left, 11 load
//   usr_i            USR parallel data
//   usr_ir, usr_il   USR serial inputs for right / left shift
//   usr_q            USR contents, fed back for rotate / arithmetic fill
//   busy             high in LOAD, SHIFT, DONE
//   done             one-cycle completion pulse
//   result           USR contents, meaningful while done is high
module usr_shift_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       usr_sel,
  output logic [WIDTH-1:0] usr_i,
  output logic             usr_ir,
  output logic             usr_il,
  input  logic [WIDTH-1:0] usr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  state_t             state_q;
  state_t             state_d;
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   data_q;
  logic               accept_c;
  logic               load_only_c;

  assign accept_c    = (state_q == ST_IDLE) && cmd_valid;
  // 110/111 behave as load-only: no shift steps
  assign load_only_c = (cmd_op == OP_LOAD) || (cmd_op[2:1] == 2'b11);
  assign result      = usr_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latch and remaining-step counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= 3'b000;
      cnt_q  <= '0;
      data_q <= '0;
    end else if (accept_c) begin
      op_q   <= cmd_op;
      cnt_q  <= load_only_c ? CNT_W'(0) : cmd_count;
      data_q <= cmd_data;
    end else if ((state_q == ST_SHIFT) && (cnt_q != '0)) begin
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  // Next-state and state-decoded outputs; serial fill follows live usr_q
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    usr_sel   = SEL_HOLD;
    usr_i     = '0;
    usr_ir    = 1'b0;
    usr_il    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        busy    = 1'b1;
        usr_sel = SEL_LOAD;
        usr_i   = data_q;
        state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
      end

      ST_SHIFT: begin
        busy  = 1'b1;
        usr_i = data_q;
        case (op_q)
          OP_SRL: begin
            usr_sel = SEL_RIGHT;
          end
          OP_SLL: begin
            usr_sel = SEL_LEFT;
          end
          OP_ROR: begin
            usr_sel = SEL_RIGHT;
            usr_ir  = usr_q[0];
          end
          OP_ROL: begin
            usr_sel = SEL_LEFT;
            usr_il  = usr_q[WIDTH-1];
          end
          OP_SRA: begin
            usr_sel = SEL_RIGHT;
            usr_ir  = usr_q[WIDTH-1];
          end
          default: begin
            usr_sel = SEL_HOLD;
          end
        endcase
        // Counter holds the steps still to apply, including this one
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        usr_i   = data_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
